// File: rtl/axis_arb_pkg.sv
// Shared types, widths and helpers for the packet round-robin AXI-Stream arbiter.
package axis_arb_pkg;

  typedef enum logic {ST_IDLE, ST_BUSY} arb_state_t;

  localparam int unsigned PKT_CNT_W = 16;

  function automatic int unsigned src_id_w(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/axis_pkt_rr_arb_if.sv
// Source-side and master-side AXI-Stream signals of the packet arbiter.
// master: arbiter view (drives M_AXIS and source readies); slave: environment view.
interface axis_pkt_rr_arb_if #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned DATA_W  = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [NUM_SRC*DATA_W-1:0] s_tdata;
  logic [NUM_SRC*STRB_W-1:0] s_tstrb;
  logic [NUM_SRC-1:0]        s_tlast;
  logic [NUM_SRC-1:0]        s_tvalid;
  logic [NUM_SRC-1:0]        s_tready;
  logic [DATA_W-1:0]         m_tdata;
  logic [STRB_W-1:0]         m_tstrb;
  logic                      m_tlast;
  logic                      m_tvalid;
  logic                      m_tready;

  modport master (
    input  s_tdata, s_tstrb, s_tlast, s_tvalid, m_tready,
    output s_tready, m_tdata, m_tstrb, m_tlast, m_tvalid
  );

  modport slave (
    output s_tdata, s_tstrb, s_tlast, s_tvalid, m_tready,
    input  s_tready, m_tdata, m_tstrb, m_tlast, m_tvalid
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set req bit scanning last+1, last+2, ... mod N.
module rr_pick
  import axis_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = src_id_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] gnt_id,
  output logic         gnt_vld
);

  int unsigned idx;

  always_comb begin
    gnt_id  = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(last) + i) % N;
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = W'(idx);
      end
    end
  end

endmodule

// File: rtl/axis_pkt_rr_arb.sv
// Packet-granular round-robin arbiter: one source owns M_AXIS from first beat to tlast.
module axis_pkt_rr_arb
  import axis_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BEATS = 512
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         arb_en,
  axis_pkt_rr_arb_if.master            bus,
  output logic                         pkt_done,
  output logic [src_id_w(NUM_SRC)-1:0] pkt_src,
  output logic [PKT_CNT_W-1:0]         pkt_cnt,
  output logic                         ovl_err,
  input  logic                         err_clr
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned SRC_W  = src_id_w(NUM_SRC);
  localparam int unsigned BEAT_W = $clog2(MAX_BEATS + 1);

  localparam logic StIdle = ST_IDLE;
  localparam logic StBusy = ST_BUSY;

  logic                 state_q, state_d;
  logic [SRC_W-1:0]     grant_q, grant_d;
  logic [SRC_W-1:0]     last_q, last_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [PKT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 ovl_q, ovl_d;
  logic                 done_q, done_d;
  logic [SRC_W-1:0]     src_q, src_d;

  logic [SRC_W-1:0]     pick_id;
  logic                 pick_vld;
  logic                 hs;

  rr_pick #(
    .N (NUM_SRC),
    .W (SRC_W)
  ) u_pick (
    .req     (bus.s_tvalid),
    .last    (last_q),
    .gnt_id  (pick_id),
    .gnt_vld (pick_vld)
  );

  // Zero-latency pass-through of the granted source while BUSY.
  always_comb begin
    bus.m_tdata  = '0;
    bus.m_tstrb  = '0;
    bus.m_tlast  = 1'b0;
    bus.m_tvalid = 1'b0;
    bus.s_tready = '0;
    if (state_q == StBusy) begin
      bus.m_tdata           = bus.s_tdata[int'(grant_q)*DATA_W +: DATA_W];
      bus.m_tstrb           = bus.s_tstrb[int'(grant_q)*STRB_W +: STRB_W];
      bus.m_tlast           = bus.s_tlast[grant_q];
      bus.m_tvalid          = bus.s_tvalid[grant_q];
      bus.s_tready[grant_q] = bus.m_tready;
    end
  end

  assign hs = bus.m_tvalid && bus.m_tready;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    ovl_d   = ovl_q;
    done_d  = 1'b0;
    src_d   = src_q;
    if (state_q == StIdle) begin
      if (arb_en && pick_vld) begin
        grant_d = pick_id;
        state_d = StBusy;
      end
    end else if (hs) begin
      if (bus.m_tlast) begin
        last_d  = grant_q;
        beat_d  = '0;
        done_d  = 1'b1;
        src_d   = grant_q;
        cnt_d   = cnt_q + 1'b1;
        state_d = StIdle;
      end else if (beat_q != BEAT_W'(MAX_BEATS)) begin
        beat_d = beat_q + 1'b1;
      end
    end
    // A new overlength event takes precedence over a same-cycle clear.
    if (err_clr) ovl_d = 1'b0;
    if (hs && !bus.m_tlast && beat_q == BEAT_W'(MAX_BEATS - 1)) ovl_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= SRC_W'(NUM_SRC - 1);
      beat_q  <= '0;
      cnt_q   <= '0;
      ovl_q   <= 1'b0;
      done_q  <= 1'b0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      ovl_q   <= ovl_d;
      done_q  <= done_d;
      src_q   <= src_d;
    end
  end

  assign pkt_done = done_q;
  assign pkt_src  = src_q;
  assign pkt_cnt  = cnt_q;
  assign ovl_err  = ovl_q;

endmodule

// File: tb/tb_axis_pkt_rr_arb.sv
// Directed bench for axis_pkt_rr_arb: 4 sources, 32-bit data, MAX_BEATS=4.
// Source beat data is {src, pkt_no, beat} so expected values follow from the stimulus.
module tb_axis_pkt_rr_arb;

  logic       clk;
  logic       rst;
  logic       arb_en;
  logic       err_clr;
  logic       pkt_done;
  logic [1:0] pkt_src;
  logic [15:0] pkt_cnt;
  logic       ovl_err;

  int n_cmp = 0;
  int n_err = 0;

  int rem  [4];
  int len  [4];
  int beat [4];
  int pno  [4];
  logic [3:0] strb [4];

  axis_pkt_rr_arb_if #(.NUM_SRC(4), .DATA_W(32)) bus ();

  axis_pkt_rr_arb #(
    .NUM_SRC   (4),
    .DATA_W    (32),
    .MAX_BEATS (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .arb_en   (arb_en),
    .bus      (bus),
    .pkt_done (pkt_done),
    .pkt_src  (pkt_src),
    .pkt_cnt  (pkt_cnt),
    .ovl_err  (ovl_err),
    .err_clr  (err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input int s, input int p, input int b);
    return {8'(s), 8'(p), 16'(b)};
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      bus.s_tvalid[i]          = rem[i] != 0;
      bus.s_tdata[i*32 +: 32]  = word(i, pno[i], beat[i]);
      bus.s_tstrb[i*4 +: 4]    = strb[i];
      bus.s_tlast[i]           = beat[i] == len[i] - 1;
    end
  endtask

  task automatic settle();
    drive();
    #1;
  endtask

  // One clock: sources advance on their own handshakes, then re-present data.
  task automatic cyc();
    logic [3:0] hs;
    hs = bus.s_tvalid & bus.s_tready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (hs[i]) begin
        if (beat[i] == len[i] - 1) begin
          beat[i] = 0;
          pno[i]  = pno[i] + 1;
          rem[i]  = rem[i] - 1;
        end else begin
          beat[i] = beat[i] + 1;
        end
      end
    end
    settle();
  endtask

  initial begin
    int exp_g [5];
    int exp_pn [5];
    int hb;
    exp_g  = '{0, 1, 2, 3, 0};
    exp_pn = '{0, 0, 0, 0, 1};

    rst     = 1'b1;
    arb_en  = 1'b1;
    err_clr = 1'b0;
    bus.m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rem[i] = (i == 0) ? 2 : 1;
      len[i] = 4;
      beat[i] = 0;
      pno[i] = 0;
      strb[i] = 4'hF;
    end
    settle();
    repeat (3) cyc();

    // Reset state
    chk("rst_mvalid", 32'(bus.m_tvalid), 32'd0);
    chk("rst_sready", 32'(bus.s_tready), 32'd0);
    chk("rst_cnt", 32'(pkt_cnt), 32'd0);
    chk("rst_ovl", 32'(ovl_err), 32'd0);
    chk("rst_done", 32'(pkt_done), 32'd0);
    chk("rst_src", 32'(pkt_src), 32'd0);
    rst = 1'b0;
    settle();

    // 1: all sources valid, rotation 0,1,2,3,0 with one idle cycle per packet
    for (int p = 0; p < 5; p++) begin
      chk("t1_idle", 32'(bus.m_tvalid), 32'd0);
      cyc();
      for (int b = 0; b < 4; b++) begin
        chk("t1_sready", 32'(bus.s_tready), 32'(1 << exp_g[p]));
        chk("t1_data", bus.m_tdata, word(exp_g[p], exp_pn[p], b));
        chk("t1_last", 32'(bus.m_tlast), 32'(b == 3));
        if (b == 0) chk("t1_strb", 32'(bus.m_tstrb), 32'hF);
        cyc();
      end
      chk("t1_done", 32'(pkt_done), 32'd1);
      chk("t1_src", 32'(pkt_src), 32'(exp_g[p]));
      chk("t1_cnt", 32'(pkt_cnt), 32'(p + 1));
    end

    // 2: single-beat packet from src2 with partial strobe
    len[2] = 1;
    strb[2] = 4'b0011;
    rem[2] = 1;
    settle();
    chk("t2_idle", 32'(bus.m_tvalid), 32'd0);
    cyc();
    chk("t2_mvalid", 32'(bus.m_tvalid), 32'd1);
    chk("t2_strb", 32'(bus.m_tstrb), 32'h3);
    chk("t2_last", 32'(bus.m_tlast), 32'd1);
    chk("t2_data", bus.m_tdata, word(2, 1, 0));
    chk("t2_sready", 32'(bus.s_tready), 32'b0100);
    cyc();
    chk("t2_done", 32'(pkt_done), 32'd1);
    chk("t2_src", 32'(pkt_src), 32'd2);
    chk("t2_cnt", 32'(pkt_cnt), 32'd6);
    chk("t2_mvalid_off", 32'(bus.m_tvalid), 32'd0);

    // 3: 8-beat packet from src1 with m_tready toggling
    len[1] = 8;
    rem[1] = 1;
    settle();
    cyc();
    hb = 0;
    for (int c = 0; c < 16 && hb < 8; c++) begin
      bus.m_tready = (c % 2) == 0;
      settle();
      chk("t3_mvalid", 32'(bus.m_tvalid), 32'd1);
      chk("t3_data", bus.m_tdata, word(1, 1, hb));
      chk("t3_last", 32'(bus.m_tlast), 32'(hb == 7));
      chk("t3_sready", 32'(bus.s_tready), bus.m_tready ? 32'b0010 : 32'd0);
      if (bus.m_tready) hb++;
      cyc();
    end
    bus.m_tready = 1'b1;
    settle();
    chk("t3_done", 32'(pkt_done), 32'd1);
    chk("t3_src", 32'(pkt_src), 32'd1);
    chk("t3_cnt", 32'(pkt_cnt), 32'd7);
    chk("t3_ovl", 32'(ovl_err), 32'd1);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    settle();
    chk("t3_ovl_clr", 32'(ovl_err), 32'd0);

    // 4: 6-beat packet from src0 overruns MAX_BEATS=4; clear in same cycle as set loses
    len[0] = 6;
    rem[0] = 1;
    settle();
    cyc();
    for (int b = 0; b < 6; b++) begin
      if (b == 3) err_clr = 1'b1;
      settle();
      chk("t4_ovl", 32'(ovl_err), 32'(b >= 4));
      chk("t4_data", bus.m_tdata, word(0, 2, b));
      chk("t4_last", 32'(bus.m_tlast), 32'(b == 5));
      cyc();
      err_clr = 1'b0;
    end
    settle();
    chk("t4_done", 32'(pkt_done), 32'd1);
    chk("t4_cnt", 32'(pkt_cnt), 32'd8);
    chk("t4_ovl_held", 32'(ovl_err), 32'd1);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    settle();
    chk("t4_ovl_clr", 32'(ovl_err), 32'd0);

    // 5: arb_en drops mid-packet of src3; src0 waits until re-enabled
    len[0] = 4;
    len[3] = 4;
    rem[0] = 1;
    rem[3] = 1;
    settle();
    cyc();
    chk("t5_sready3", 32'(bus.s_tready), 32'b1000);
    cyc();
    arb_en = 1'b0;
    settle();
    for (int b = 1; b < 4; b++) begin
      chk("t5_data", bus.m_tdata, word(3, 1, b));
      cyc();
    end
    chk("t5_done", 32'(pkt_done), 32'd1);
    chk("t5_src", 32'(pkt_src), 32'd3);
    chk("t5_cnt", 32'(pkt_cnt), 32'd9);
    repeat (3) begin
      chk("t5_hold_mvalid", 32'(bus.m_tvalid), 32'd0);
      chk("t5_hold_sready", 32'(bus.s_tready), 32'd0);
      cyc();
    end
    arb_en = 1'b1;
    settle();
    chk("t5_reen_idle", 32'(bus.m_tvalid), 32'd0);
    cyc();
    for (int b = 0; b < 4; b++) begin
      chk("t5_sready0", 32'(bus.s_tready), 32'b0001);
      chk("t5_data0", bus.m_tdata, word(0, 3, b));
      cyc();
    end
    chk("t5_src0", 32'(pkt_src), 32'd0);
    chk("t5_cnt0", 32'(pkt_cnt), 32'd10);

    // 6: reset at beat 2 of a src1 packet
    rem[1] = 1;
    len[1] = 4;
    settle();
    cyc();
    chk("t6_sready1", 32'(bus.s_tready), 32'b0010);
    cyc();
    cyc();
    chk("t6_data", bus.m_tdata, word(1, 2, 2));
    rst = 1'b1;
    cyc();
    chk("t6_mvalid", 32'(bus.m_tvalid), 32'd0);
    chk("t6_sready", 32'(bus.s_tready), 32'd0);
    chk("t6_cnt", 32'(pkt_cnt), 32'd0);
    chk("t6_done", 32'(pkt_done), 32'd0);
    beat[1] = 0;
    rem[0] = 1;
    rem[1] = 1;
    rst = 1'b0;
    settle();
    chk("t6_idle", 32'(bus.m_tvalid), 32'd0);
    cyc();
    chk("t6_first_grant", 32'(bus.s_tready), 32'b0001);
    chk("t6_first_data", bus.m_tdata, word(0, 4, 0));
    repeat (4) cyc();
    chk("t6_pkt_done", 32'(pkt_done), 32'd1);
    chk("t6_pkt_src", 32'(pkt_src), 32'd0);
    chk("t6_pkt_cnt", 32'(pkt_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
